uart_rx_fifo: RTL
=================

# uart_rx_fifo

Parametrised UART receiver with configurable frame format, error detection and an internal receive FIFO. It replaces the single-byte, single-register receiver. Serial `Rx` comes in from the pin. Buffered words go out to the host logic through a valid/ack pop handshake, with sticky error flags alongside.

## Interface
- `CLKS_PER_BIT`, 30: `Clk` cycles per bit (Clk/BAUD); legal range ≥ 4.
- `DATA_BITS`, 8: data bits per frame, 5..8, LSB first.
- `DEPTH_LOG2`, 2: FIFO depth = 2**DEPTH_LOG2 words.
- `PARITY_ODD`, 0: 1 = odd parity, 0 = even; only used when `UART_RX_PARITY_EN` is defined.
- `Clk`  in  1  system clock; the only clock.
- `Reset`  in  1  synchronous, active-high reset.
- `Rx`  in  1  asynchronous serial input, idle high.
- `Data`  out  DATA_BITS  FIFO head word; meaningful only while `Valid`=1.
- `Valid`  out  1  FIFO non-empty.
- `Ack`  in  1  pop; acts on any rising edge where `Valid`=1 and `Ack`=1; ignored when empty.
- `Level`  out  DEPTH_LOG2+1  number of words held, 0..2**DEPTH_LOG2.
- `Busy`  out  1  state ≠ IDLE.
- `FrameErr`  out  1  sticky: stop bit sampled low.
- `ParityErr`  out  1  sticky: parity mismatch (tied 0 when the macro is undefined).
- `Overrun`  out  1  sticky: completed word dropped because the FIFO was full.
- `ErrClear`  in  1  single-cycle pulse that clears all three sticky flags.

## Operation
- `Rx` passes through a 2-FF synchroniser. Both stages reset to 1.
- Bit timer width is $clog2(CLKS_PER_BIT). Bit counter width is 3.
- IDLE: on synchronised `Rx`=0, load timer with CLKS_PER_BIT/2−1 and go to START.
- START: at timer=0, sample the line.
  - If 1, treat as a glitch and return to IDLE.
  - If 0, load timer with CLKS_PER_BIT−1, clear the bit counter and go to DATA.
- DATA: at each timer=0, shift the sample in at the MSB of a DATA_BITS shift register (LSB first on the line) and reload the timer.
  - After DATA_BITS samples, go to PARITY if the macro is defined, else to STOP.
- PARITY: at timer=0, capture the bit, reload the timer and go to STOP.
- STOP: at timer=0, sample the line.
  - 1 with no parity error: push the word and go to IDLE.
  - 1 with a parity error: set `ParityErr`, discard the word, go to IDLE.
  - 0: set `FrameErr`, discard the word, go to WAITHI.
- WAITHI: remain until synchronised `Rx`=1, then go to IDLE. This covers a break or line held low.
- Push when full: drop the word and set `Overrun`. FIFO contents are unchanged.
- Push and pop in the same cycle:
  - When full, the pop frees the slot, the word is accepted, `Overrun` is not set and `Level` stays at max.
  - Otherwise `Level` is unchanged and pointers advance.
- Pointers are DEPTH_LOG2 bits and wrap naturally. `Level` is a separate counter.
- `ErrClear` coinciding with a new error: the set wins.
- Reset values:
  - State IDLE.
  - Pointers, `Level`, `Valid`, `Data`, `Busy` and all flags = 0.
  - Shift register = 0.
- Reset mid-frame: the partial word is lost and FIFO contents are flushed.

## Timing
- Synchroniser latency: 2 cycles from the pin.
- Start edge to the mid-start sample: CLKS_PER_BIT/2 cycles.
- Successive samples are CLKS_PER_BIT cycles apart.
- Push occurs on the edge of the mid-stop sample.
- `Valid`, `Level` and `Data` update on the following edge, i.e. registered with 1-cycle latency.
- `Data` is read from the register array at the read pointer, so it is stable for as long as `Valid` is held without `Ack`.
- Pop takes effect on the `Ack` edge. The next word, or `Valid`=0, appears 1 cycle later.
- Back-to-back frames are supported: the next start bit is detected from the first IDLE cycle after STOP, i.e. half a bit early.
- Errors assert 1 cycle after the offending sample. `ErrClear` takes effect on the next edge.

## Configuration
- `UART_RX_PARITY_EN` defined:
  - The PARITY state, checker, `PARITY_ODD` and `ParityErr` are live.
  - Frame is start + DATA_BITS + parity + stop.
- `UART_RX_PARITY_EN` undefined:
  - No parity logic; `ParityErr` is tied to 0.
  - Frame is start + DATA_BITS + stop.

## Test plan
All scenarios use CLKS_PER_BIT=30, DATA_BITS=8, DEPTH_LOG2=2.

- Send 0x55 as 8N1 → after about 288 cycles `Valid`=1, `Data`=0x55, `Level`=1. Pulse `Ack` → next cycle `Valid`=0, `Level`=0.
- Low pulse of 10 cycles on `Rx` → returns to IDLE after START. No push, `Level`=0, `Busy` back to 0.
- Send 0xA3 with the stop bit forced 0, hold `Rx` low 100 cycles, then send 0x3C → 0xA3 dropped, `FrameErr`=1. 0x3C is received (`Level`=1). `ErrClear` → `FrameErr`=0.
- Send 0x01..0x05 without `Ack` → `Level`=4, `Overrun`=1. Four pops return 0x01, 0x02, 0x03, 0x04.
  - Repeat with `Ack` on the same cycle as the 5th push → `Overrun`=0, `Level`=4.
- Macro defined, `PARITY_ODD`=0:
  - 0x07 with parity bit 1 → accepted.
  - 0x07 with parity bit 0 → `ParityErr`=1 and the word is discarded.
- Assert `Reset` after the 4th data bit of 0x81 → next cycle all outputs 0. A fresh 0x81 afterwards is received correctly.

Source files
------------

// File: rtl/uart_rx_fifo.sv
// UART receiver with configurable frame format, sticky error flags and a receive FIFO.
// Optional parity checking is compiled in with `define UART_RX_PARITY_EN.
module uart_rx_fifo #(
    parameter int unsigned CLKS_PER_BIT = 30,
    parameter int unsigned DATA_BITS    = 8,
    parameter int unsigned DEPTH_LOG2   = 2,
    parameter int unsigned PARITY_ODD   = 0
) (
    input  logic                  Clk,
    input  logic                  Reset,
    input  logic                  Rx,
    output logic [DATA_BITS-1:0]  Data,
    output logic                  Valid,
    input  logic                  Ack,
    output logic [DEPTH_LOG2:0]   Level,
    output logic                  Busy,
    output logic                  FrameErr,
    output logic                  ParityErr,
    output logic                  Overrun,
    input  logic                  ErrClear
);

    localparam int unsigned TW    = $clog2(CLKS_PER_BIT);
    localparam int unsigned DEPTH = 1 << DEPTH_LOG2;

    localparam logic [TW-1:0]         T_ONE  = TW'(1);
    localparam logic [TW-1:0]         T_FULL = TW'(CLKS_PER_BIT - 1);
    localparam logic [TW-1:0]         T_HALF = TW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [2:0]            B_LAST = 3'(DATA_BITS - 1);
    localparam logic [DEPTH_LOG2-1:0] P_ONE  = DEPTH_LOG2'(1);
    localparam logic [DEPTH_LOG2:0]   L_ONE  = (DEPTH_LOG2 + 1)'(1);
    localparam logic [DEPTH_LOG2:0]   L_MAX  = (DEPTH_LOG2 + 1)'(DEPTH);

    if (CLKS_PER_BIT < 4 || DATA_BITS < 5 || DATA_BITS > 8 || PARITY_ODD > 1) begin : g_bad_params
        $error("uart_rx_fifo: illegal parameter value");
    end

    typedef enum logic [2:0] {
        S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_WAITHI
    } state_t;

    state_t                 state;
    logic                   rx_s1, rx_s2;
    logic [TW-1:0]          timer;
    logic [2:0]             bitcnt;
    logic [DATA_BITS-1:0]   shreg;
    logic                   push_req;

    logic [DATA_BITS-1:0]   mem [DEPTH];
    logic [DEPTH_LOG2-1:0]  wr_ptr, rd_ptr;
    logic                   full, pop, push_ok;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            rx_s1 <= 1'b1;
            rx_s2 <= 1'b1;
        end else begin
            rx_s1 <= Rx;
            rx_s2 <= rx_s1;
        end
    end

`ifdef UART_RX_PARITY_EN
    logic pbit;
    logic parity_bad;
    assign parity_bad = ((^shreg) ^ pbit) != 1'(PARITY_ODD);
`else
    assign ParityErr = 1'b0;
`endif

    // Flags are cleared first so that a set later in the same edge takes priority.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state    <= S_IDLE;
            timer    <= '0;
            bitcnt   <= '0;
            shreg    <= '0;
            push_req <= 1'b0;
            FrameErr <= 1'b0;
`ifdef UART_RX_PARITY_EN
            pbit      <= 1'b0;
            ParityErr <= 1'b0;
`endif
        end else begin
            push_req <= 1'b0;
            if (ErrClear) begin
                FrameErr <= 1'b0;
`ifdef UART_RX_PARITY_EN
                ParityErr <= 1'b0;
`endif
            end
            case (state)
                S_IDLE: begin
                    if (!rx_s2) begin
                        timer <= T_HALF;
                        state <= S_START;
                    end
                end
                S_START: begin
                    if (timer == '0) begin
                        if (rx_s2) begin
                            state <= S_IDLE;
                        end else begin
                            timer  <= T_FULL;
                            bitcnt <= '0;
                            state  <= S_DATA;
                        end
                    end else begin
                        timer <= timer - T_ONE;
                    end
                end
                S_DATA: begin
                    if (timer == '0) begin
                        shreg  <= {rx_s2, shreg[DATA_BITS-1:1]};
                        timer  <= T_FULL;
                        bitcnt <= bitcnt + 3'd1;
                        if (bitcnt == B_LAST) begin
`ifdef UART_RX_PARITY_EN
                            state <= S_PARITY;
`else
                            state <= S_STOP;
`endif
                        end
                    end else begin
                        timer <= timer - T_ONE;
                    end
                end
`ifdef UART_RX_PARITY_EN
                S_PARITY: begin
                    if (timer == '0) begin
                        pbit  <= rx_s2;
                        timer <= T_FULL;
                        state <= S_STOP;
                    end else begin
                        timer <= timer - T_ONE;
                    end
                end
`endif
                S_STOP: begin
                    if (timer == '0) begin
                        if (!rx_s2) begin
                            FrameErr <= 1'b1;
                            state    <= S_WAITHI;
`ifdef UART_RX_PARITY_EN
                        end else if (parity_bad) begin
                            ParityErr <= 1'b1;
                            state     <= S_IDLE;
`endif
                        end else begin
                            push_req <= 1'b1;
                            state    <= S_IDLE;
                        end
                    end else begin
                        timer <= timer - T_ONE;
                    end
                end
                S_WAITHI: begin
                    if (rx_s2) state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign Busy  = (state != S_IDLE);
    assign Valid = (Level != '0);
    assign Data  = mem[rd_ptr];

    assign full    = (Level == L_MAX);
    assign pop     = Ack && Valid;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts the word.
    assign push_ok = push_req && (!full || pop);

    always_ff @(posedge Clk) begin
        if (Reset) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            Level   <= '0;
            Overrun <= 1'b0;
            for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else begin
            if (ErrClear) Overrun <= 1'b0;
            if (push_req && !push_ok) Overrun <= 1'b1;
            if (push_ok) begin
                mem[wr_ptr] <= shreg;
                wr_ptr      <= wr_ptr + P_ONE;
            end
            if (pop) rd_ptr <= rd_ptr + P_ONE;
            if (push_ok && !pop) Level <= Level + L_ONE;
            else if (!push_ok && pop) Level <= Level - L_ONE;
        end
    end

endmodule
